// File: rtl/alu32_pkg.sv
// Shared definitions for the ALU write-back stage: opcode map, flag bit
// positions and the buffered entry layout.
package alu32_pkg;

  localparam int ALU_W  = 32;
  localparam int OP_W   = 3;
  localparam int FLAG_W = 5;

  // ALU select codes
  localparam logic [OP_W-1:0] OP_AND = 3'd0;
  localparam logic [OP_W-1:0] OP_OR  = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR = 3'd2;
  localparam logic [OP_W-1:0] OP_NOT = 3'd3;
  localparam logic [OP_W-1:0] OP_ADD = 3'd4;
  localparam logic [OP_W-1:0] OP_SH  = 3'd5;  // In2-directed shift
  localparam logic [OP_W-1:0] OP_OSH = 3'd6;  // opposite shift
  localparam logic [OP_W-1:0] OP_RSV = 3'd7;  // reserved, ALU returns 0

  // Bit positions inside the flags field {IL,V,C,N,Z}
  localparam int FLG_Z  = 0;
  localparam int FLG_N  = 1;
  localparam int FLG_C  = 2;
  localparam int FLG_V  = 3;
  localparam int FLG_IL = 4;

  typedef struct packed {
    logic [ALU_W-1:0]  result;
    logic [OP_W-1:0]   op;
    logic [FLAG_W-1:0] flags;
  } wb_entry_t;

endpackage

// File: rtl/alu32_wb_fifo.sv
// Generic DEPTH-entry synchronous FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
// Read data is forced to zero while empty so stale or uninitialised
// storage never reaches the outputs.
module alu32_wb_fifo
  import alu32_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_W + 1;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_BITS-1:0] count_q;
  logic                do_push;
  logic                do_pop;

  assign full    = (count_q == CNT_BITS'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Storage write; entry written at the write pointer on an accepted push
  // NOTE: storage is deliberately not reset - validity comes from count_q, and
  // a resettable array would cost a reset mux on every bit.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer and occupancy update; reset discards all buffered entries
  // NOTE: state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_BITS'(1);
        2'b01:   count_q <= count_q - CNT_BITS'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu32_writeback_stage.sv
// Registered write-back stage behind the 32-bit ALU. Captures result,
// opcode and derived flags {IL,V,C,N,Z} into a small FIFO drained by the
// register-file / flag-register consumer over valid/ready.
// Optional build macro ALU32_WB_OVF_EN: when defined, V reports signed add
// overflow and is stored per entry; otherwise V reads as 0 and has no storage.
// WIDTH must equal the ALU width (alu32_pkg::ALU_W).
module alu32_writeback_stage
  import alu32_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   InValid,
  output logic                   InReady,
  input  logic [OP_W-1:0]        Op,
  input  logic [WIDTH-1:0]       Result,
  input  logic                   CO,
  input  logic                   In1Msb,
  input  logic                   In2Msb,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [WIDTH-1:0]       OutResult,
  output logic [OP_W-1:0]        OutOp,
  output logic [FLAG_W-1:0]      OutFlags,
  output logic [$clog2(DEPTH):0] Count,
  output logic [CNT_W-1:0]       OpCount
);

`ifdef ALU32_WB_OVF_EN
  localparam int STORE_FLAG_W = FLAG_W;
`else
  localparam int STORE_FLAG_W = FLAG_W - 1;
`endif
  localparam int DATA_W = WIDTH + OP_W + STORE_FLAG_W;

  logic              flag_z;
  logic              flag_n;
  logic              flag_c;
  logic              flag_il;
`ifdef ALU32_WB_OVF_EN
  logic              flag_v;
`else
  logic              unused_msbs;
`endif
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic [CNT_W-1:0]  op_cnt_q;
  wb_entry_t         head;

  // Ready depends only on reset and registered occupancy; a pop in the same
  // cycle never frees a slot for a push.
  assign InReady = !RST && !full;
  assign push    = InValid && InReady;
  assign pop     = OutValid && OutReady;

  // Flag derivation from the ALU outputs presented at the push edge
  always_comb begin
    flag_z  = (Result == '0);
    flag_n  = Result[WIDTH-1];
    flag_c  = (Op == OP_ADD) && CO;
    flag_il = (Op == OP_RSV);
`ifdef ALU32_WB_OVF_EN
    flag_v  = (Op == OP_ADD) && (In1Msb == In2Msb) && (Result[WIDTH-1] != In1Msb);
`endif
  end

  // Stored flag bits keep their FLG_* order, minus V when it is not built.
`ifdef ALU32_WB_OVF_EN
  assign wdata = {Result, Op, flag_il, flag_v, flag_c, flag_n, flag_z};
`else
  assign unused_msbs = In1Msb ^ In2Msb;
  assign wdata = {Result, Op, flag_il, flag_c, flag_n, flag_z};
`endif

  alu32_wb_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (Count),
    .full  (full),
    .empty (empty)
  );

  // Unpack the head entry back into the full {IL,V,C,N,Z} layout
  always_comb begin
    // NOTE: default the whole struct first so no field can infer a latch.
    head               = '0;
    head.result        = rdata[DATA_W-1 -: WIDTH];
    head.op            = rdata[STORE_FLAG_W +: OP_W];
    head.flags[FLG_Z]  = rdata[0];
    head.flags[FLG_N]  = rdata[1];
    head.flags[FLG_C]  = rdata[2];
`ifdef ALU32_WB_OVF_EN
    head.flags[FLG_V]  = rdata[3];
    head.flags[FLG_IL] = rdata[4];
`else
    head.flags[FLG_IL] = rdata[3];
`endif
  end

  assign OutValid  = !empty;
  assign OutResult = head.result;
  assign OutOp     = head.op;
  assign OutFlags  = head.flags;
  assign OpCount   = op_cnt_q;

  // Saturating count of accepted entries
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_cnt_q <= '0;
    end else if (push && (op_cnt_q != '1)) begin
      op_cnt_q <= op_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: doc/alu32_writeback_stage.md
Name: alu32_writeback_stage

Overview:
- Registered write-back stage directly downstream of the 32-bit gate-level ALU.
- Captures the ALU result, carry-out and opcode, derives status flags, and buffers entries in a DEPTH-entry FIFO.
- Consumer (register-file write port / flag register) drains the FIFO over a valid/ready handshake.
- Decouples the combinational ALU path from write-back timing.

Parameters:
- WIDTH, 32, data width of result; must match ALU width.
- DEPTH, 2, FIFO entries; power of two, 2..16.
- CNT_W, 16, width of saturating accepted-operation counter.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous reset, active-high.
- InValid  input  1  ALU result presented this cycle.
- InReady  output  1  stage can accept an entry.
- Op  input  3  ALU select code that produced Result.
- Result  input  WIDTH  ALU FinalOut.
- CO  input  1  ALU carry-out.
- In1Msb  input  1  MSB of ALU operand In1.
- In2Msb  input  1  MSB of ALU operand In2.
- OutValid  output  1  head entry valid.
- OutReady  input  1  consumer takes head entry.
- OutResult  output  WIDTH  head result.
- OutOp  output  3  head opcode.
- OutFlags  output  5  head flags {IL,V,C,N,Z}.
- Count  output  $clog2(DEPTH)+1  current occupancy.
- OpCount  output  CNT_W  saturating count of accepted entries.

Behaviour:
- Interface: one clock, CLK; synchronous active-high reset, RST.
- Reset (RST high at a CLK edge):
  - read/write pointers, Count and OpCount all 0.
  - OutValid 0; OutResult, OutOp and OutFlags 0.
  - InReady 0 while RST is high, 1 from the first cycle after RST deasserts.
  - Reset mid-operation discards all buffered entries.
- Opcode map (fixed):
  - 0 AND, 1 OR, 2 XOR, 3 NOT, 4 ADD, 5 shift (In2-directed), 6 opposite shift.
  - 7 reserved; ALU returns 0.
- Flags, computed from inputs at the push edge and stored with the entry:
  - Z = (Result == 0); N = Result[WIDTH-1].
  - C = CO when Op==4, else 0.
  - IL = (Op==7).
  - V: see Optional Feature.
- Push: InValid && InReady at a rising edge writes the entry at the write pointer.
- Pop: OutValid && OutReady at a rising edge advances the read pointer.
- InReady = (Count < DEPTH), driven from registered state only. There is no combinational path from OutReady to InReady, so a full FIFO does not accept even if a pop occurs in the same cycle.
- OutValid = (Count != 0). OutResult, OutOp and OutFlags are the head entry, forced to 0 when empty.
- Latency: an entry pushed into an empty FIFO appears on the outputs the cycle after the push edge. There is no same-cycle bypass.
- Simultaneous push and pop with 0 < Count < DEPTH: Count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Count is held in an extra bit so full and empty are unambiguous.
- Output data must hold stable while OutValid && !OutReady.
- OpCount increments by 1 per push and saturates at 2^CNT_W-1 (no wrap).
- InValid while !InReady is ignored; the upstream must hold its data.
- X on Result while InValid=0 must not propagate into any output.

Optional Feature:
- Macro: ALU32_WB_OVF_EN.
- Defined: V = (Op==4) && (In1Msb==In2Msb) && (Result[WIDTH-1]!=In1Msb), i.e. signed add overflow.
- Undefined: V is tied 0, In1Msb/In2Msb are unused, and the storage bit for V is not instantiated.
- Port list is identical in both builds.

Decomposition:
- Package alu32_pkg:
  - opcode localparams OP_AND..OP_RSV.
  - flag bit indices FLG_Z=0, FLG_N=1, FLG_C=2, FLG_V=3, FLG_IL=4.
  - packed struct wb_entry_t {result, op, flags}.
- One sub-module, alu32_wb_fifo: generic DEPTH-entry synchronous FIFO of wb_entry_t with count and full/empty.
- Flag derivation stays in the top-level module.

Test Plan:
- Reset then idle: after RST, InReady=1, OutValid=0, Count=0, OpCount=0, all outputs 0.
- Push Op=4, Result=0x00000000, CO=1, OutReady=0 -> next cycle OutValid=1, OutFlags=5'b00101 (C,Z), Count=1.
- Push 3 entries back-to-back with OutReady=0, DEPTH=2 -> InReady=0 after the 2nd; 3rd is ignored; pops return the entries in order; OpCount=2.
- Steady stream with OutReady=1, Count=1: simultaneous push/pop for 10 cycles -> Count stays 1, results in order, none lost.
- Op=7, Result=0 -> flags IL=1, Z=1, C=0 even with CO=1. Op=0, Result=0x80000000 -> N=1 only.
- ALU32_WB_OVF_EN build: Op=4, In1Msb=0, In2Msb=0, Result=0x80000000 -> V=1, N=1. Same stimulus without the macro -> V=0.
